// File: rtl/uart_ctrl_defs.sv
// Shared definitions for the memory-mapped UART controller: register map,
// STATUS/CTRL bit positions, TX sequencer states and the reset divisor.
package uart_ctrl_defs;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CLKDIV = 2'd2;
    localparam logic [1:0] ADDR_CTRL   = 2'd3;

    localparam int ST_RXAVAIL = 0;
    localparam int ST_TXFULL  = 1;
    localparam int ST_TXEMPTY = 2;
    localparam int ST_RXOVR   = 3;
    localparam int ST_RXERR   = 4;
    localparam int ST_TXOVF   = 5;
    localparam int ST_TXBUSY  = 6;

    localparam int CTRL_RXIE = 0;
    localparam int CTRL_TXIE = 1;

    // 50 MHz / (9600 baud x 4 oversampling)
    localparam logic [15:0] DEFAULT_CLKDIV = 16'd1302;

    typedef enum logic [1:0] {
        TX_IDLE   = 2'b00,
        TX_LAUNCH = 2'b01,
        TX_ACK    = 2'b10,
        TX_DRAIN  = 2'b11
    } tx_state_t;

    function automatic logic [15:0] pack_status(
        input logic rxavail,
        input logic txfull,
        input logic txempty,
        input logic rxovr,
        input logic rxerr,
        input logic txovf,
        input logic txbusy
    );
        logic [15:0] v;
        v             = 16'h0000;
        v[ST_RXAVAIL] = rxavail;
        v[ST_TXFULL]  = txfull;
        v[ST_TXEMPTY] = txempty;
        v[ST_RXOVR]   = rxovr;
        v[ST_RXERR]   = rxerr;
        v[ST_TXOVF]   = txovf;
        v[ST_TXBUSY]  = txbusy;
        return v;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte-wide synchronous FIFO with fall-through head. Push and pop in the same
// cycle both take effect, even when full; an empty FIFO presents 8'h00.
module uart_fifo #(
    parameter int AW = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam int          DEPTH_I = 2 ** AW;
    localparam logic [AW:0] DEPTH   = {1'b1, {AW{1'b0}}};

    logic [7:0]    r_mem [0:DEPTH_I-1];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign empty     = (r_count == {(AW+1){1'b0}});
    assign full      = (r_count == DEPTH);
    assign w_do_pop  = pop & ~empty;
    // A pop frees the slot the push lands in, so a full FIFO still accepts it
    assign w_do_push = push & (~full | w_do_pop);

    // Head presentation, forced to zero when nothing is stored
    always_comb begin
        dout = 8'h00;
        if (empty) begin
            dout = 8'h00;
        end else begin
            dout = r_mem[r_rd_ptr];
        end
    end

    // Storage array write port
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
            r_count  <= {(AW+1){1'b0}};
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + {{(AW-1){1'b0}}, 1'b1};
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + {{AW{1'b0}}, 1'b1};
                2'b01:   r_count <= r_count - {{AW{1'b0}}, 1'b1};
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_ctrl.sv
// CPU-facing UART controller: four 16-bit registers, TX/RX byte FIFOs, a
// transmit sequencer for the core's one-cycle start handshake, and a level irq.
module uart_ctrl
    import uart_ctrl_defs::*;
#(
    parameter logic [15:0] CLOCK_DIVIDE = DEFAULT_CLKDIV,
    parameter int          FIFO_AW      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  addr,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        irq,
    output logic        uart_transmit,
    output logic [7:0]  uart_tx_byte,
    output logic [15:0] uart_clk_div,
    input  logic        uart_received,
    input  logic [7:0]  uart_rx_byte,
    input  logic        uart_recv_error,
    input  logic        uart_is_transmitting
);

    tx_state_t   r_state;
    logic        r_transmit;
    logic [7:0]  r_tx_byte;
    logic [15:0] r_data_out;
    logic [15:0] r_clkdiv;
    logic [1:0]  r_ctrl;
    logic        r_rxovr;
    logic        r_rxerr;
    logic        r_txovf;

    logic        w_tx_push;
    logic        w_tx_pop;
    logic [7:0]  w_tx_dout;
    logic        w_tx_full;
    logic        w_tx_empty;
    logic        w_rx_pop;
    logic [7:0]  w_rx_dout;
    logic        w_rx_full;
    logic        w_rx_empty;
    logic        w_sts_wr;
    logic        w_rx_drop;
    logic        w_tx_drop;
    logic        w_txbusy;
    logic [15:0] w_rd_data;

    assign w_tx_push = wr_en & (addr == ADDR_DATA);
    assign w_rx_pop  = rd_en & (addr == ADDR_DATA);
    assign w_sts_wr  = wr_en & (addr == ADDR_STATUS);
    assign w_rx_drop = uart_received & w_rx_full & ~w_rx_pop;
    assign w_tx_drop = w_tx_push & w_tx_full & ~w_tx_pop;
    assign w_txbusy  = (r_state != TX_IDLE) | uart_is_transmitting;

    uart_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_tx_push),
        .pop   (w_tx_pop),
        .din   (data_in[7:0]),
        .dout  (w_tx_dout),
        .full  (w_tx_full),
        .empty (w_tx_empty)
    );

    uart_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (uart_received),
        .pop   (w_rx_pop),
        .din   (uart_rx_byte),
        .dout  (w_rx_dout),
        .full  (w_rx_full),
        .empty (w_rx_empty)
    );

    // TX head is consumed only when the sequencer is idle and the core is free
    always_comb begin
        w_tx_pop = 1'b0;
        if ((r_state == TX_IDLE) && !w_tx_empty && !uart_is_transmitting) begin
            w_tx_pop = 1'b1;
        end else begin
            w_tx_pop = 1'b0;
        end
    end

    // Transmit sequencer: launch pulse, then follow the core's busy flag up and down
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= TX_IDLE;
            r_transmit <= 1'b0;
            r_tx_byte  <= 8'h00;
        end else begin
            case (r_state)
                TX_IDLE: begin
                    if (w_tx_pop) begin
                        r_tx_byte  <= w_tx_dout;
                        r_transmit <= 1'b1;
                        r_state    <= TX_LAUNCH;
                    end else begin
                        r_transmit <= 1'b0;
                    end
                end
                TX_LAUNCH: begin
                    r_transmit <= 1'b0;
                    r_state    <= TX_ACK;
                end
                TX_ACK: begin
                    r_transmit <= 1'b0;
                    if (uart_is_transmitting) begin
                        r_state <= TX_DRAIN;
                    end
                end
                TX_DRAIN: begin
                    r_transmit <= 1'b0;
                    if (!uart_is_transmitting) begin
                        r_state <= TX_IDLE;
                    end
                end
                default: begin
                    r_transmit <= 1'b0;
                    r_state    <= TX_IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; a new event in the same cycle overrides the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rxovr <= 1'b0;
            r_rxerr <= 1'b0;
            r_txovf <= 1'b0;
        end else begin
            r_rxovr <= w_rx_drop | (r_rxovr & ~(w_sts_wr & data_in[ST_RXOVR]));
            r_rxerr <= uart_recv_error | (r_rxerr & ~(w_sts_wr & data_in[ST_RXERR]));
            r_txovf <= w_tx_drop | (r_txovf & ~(w_sts_wr & data_in[ST_TXOVF]));
        end
    end

    // Divisor and interrupt-enable registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clkdiv <= CLOCK_DIVIDE;
            r_ctrl   <= 2'b00;
        end else begin
            if (wr_en && (addr == ADDR_CLKDIV)) begin
                r_clkdiv <= data_in;
            end
            if (wr_en && (addr == ADDR_CTRL)) begin
                r_ctrl <= data_in[1:0];
            end
        end
    end

    // Read data selection from pre-edge state
    always_comb begin
        w_rd_data = 16'h0000;
        case (addr)
            ADDR_DATA:   w_rd_data = {8'h00, w_rx_dout};
            ADDR_STATUS: w_rd_data = pack_status(~w_rx_empty, w_tx_full, w_tx_empty,
                                                 r_rxovr, r_rxerr, r_txovf, w_txbusy);
            ADDR_CLKDIV: w_rd_data = r_clkdiv;
            ADDR_CTRL:   w_rd_data = {14'h0000, r_ctrl};
            default:     w_rd_data = 16'h0000;
        endcase
    end

    // Registered read port, holds between reads
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data_out <= 16'h0000;
        end else if (rd_en) begin
            r_data_out <= w_rd_data;
        end
    end

    assign data_out      = r_data_out;
    assign uart_transmit = r_transmit;
    assign uart_tx_byte  = r_tx_byte;
    assign uart_clk_div  = r_clkdiv;
    assign irq = (r_ctrl[CTRL_RXIE] & ~w_rx_empty)
               | (r_ctrl[CTRL_TXIE] & w_tx_empty & ~w_txbusy)
               | r_rxovr | r_rxerr;

endmodule
